exp_trig_pulse_sequencer: RTL and testbench

//  Sequences the expansion-connector trigger outputs. Each of NCH channels selects one of the 16
//  DSP trigger lines (or a software strobe) and emits one timed pulse: programmable delay, width and holdoff.

---
 rtl/exp_trig_pulse_sequencer.sv | 141 ++++++++++++++
 tb/tb_exp_trig_pulse_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/exp_trig_pulse_sequencer.sv
// Expansion-connector trigger sequencer: per-channel source select, edge detect and a
// delay/pulse/holdoff sequence, with a saturating count of triggers lost while busy.
module exp_trig_pulse_sequencer #(
  parameter int unsigned NCH = 8,
  parameter int unsigned CW  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [15:0]       dsp_trig_i,
  input  logic [NCH-1:0]    arm_i,
  input  logic [NCH-1:0]    sw_trig_i,
  input  logic [NCH*4-1:0]  src_sel_i,
  input  logic [NCH*CW-1:0] delay_i,
  input  logic [NCH*CW-1:0] width_i,
  input  logic [NCH*CW-1:0] holdoff_i,
  input  logic [NCH-1:0]    miss_clr_i,
  output logic [NCH-1:0]    pulse_o,
  output logic [NCH-1:0]    busy_o,
  output logic [NCH*8-1:0]  miss_cnt_o
);

  localparam int unsigned SW = 4;
  localparam int unsigned MW = 8;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_PULSE, S_HOLD} state_t;

  state_t          state_q [NCH];
  state_t          state_d [NCH];
  logic [CW-1:0]   cnt_q   [NCH];
  logic [CW-1:0]   cnt_d   [NCH];
  logic [CW-1:0]   width_q [NCH];
  logic [CW-1:0]   width_d [NCH];
  logic [CW-1:0]   hold_q  [NCH];
  logic [CW-1:0]   hold_d  [NCH];
  logic [MW-1:0]   miss_q  [NCH];
  logic [MW-1:0]   miss_d  [NCH];
  logic [15:0]     trig_prev_q;
  logic [NCH-1:0]  pulse_q;
  logic [NCH-1:0]  pulse_d;
  logic [NCH-1:0]  edge_c;
  logic [NCH-1:0]  ev_c;

  // Pulse width of zero behaves as one cycle
  function automatic logic [CW-1:0] width_m1(input logic [CW-1:0] w);
    return (w == '0) ? '0 : w - CW'(1);
  endfunction

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign edge_c[g] = dsp_trig_i[src_sel_i[SW*g +: SW]] & ~trig_prev_q[src_sel_i[SW*g +: SW]];
    assign busy_o[g] = (state_q[g] != S_IDLE);
    assign miss_cnt_o[MW*g +: MW] = miss_q[g];
  end

  assign ev_c    = arm_i & (edge_c | sw_trig_i);
  assign pulse_o = pulse_q;

  // Per-channel next state, counters and miss accounting
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      width_d[c] = width_q[c];
      hold_d[c]  = hold_q[c];
      miss_d[c]  = miss_q[c];
      pulse_d[c] = 1'b0;

      case (state_q[c])
        S_IDLE: begin
          if (ev_c[c]) begin
            width_d[c] = width_i[CW*c +: CW];
            hold_d[c]  = holdoff_i[CW*c +: CW];
            if (delay_i[CW*c +: CW] != '0) begin
              state_d[c] = S_DELAY;
              cnt_d[c]   = delay_i[CW*c +: CW] - CW'(1);
            end else begin
              state_d[c] = S_PULSE;
              cnt_d[c]   = width_m1(width_i[CW*c +: CW]);
            end
          end
        end
        S_DELAY: begin
          if (cnt_q[c] == '0) begin
            state_d[c] = S_PULSE;
            cnt_d[c]   = width_m1(width_q[c]);
          end else begin
            cnt_d[c] = cnt_q[c] - CW'(1);
          end
        end
        S_PULSE: begin
          if (cnt_q[c] == '0) begin
            if (hold_q[c] != '0) begin
              state_d[c] = S_HOLD;
              cnt_d[c]   = hold_q[c] - CW'(1);
            end else begin
              state_d[c] = S_IDLE;
            end
          end else begin
            cnt_d[c] = cnt_q[c] - CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q[c] == '0) state_d[c] = S_IDLE;
          else                cnt_d[c]   = cnt_q[c] - CW'(1);
        end
        default: state_d[c] = S_IDLE;
      endcase

      if ((state_q[c] != S_IDLE) && ev_c[c] && (miss_q[c] != '1)) miss_d[c] = miss_q[c] + MW'(1);
      if ((state_q[c] != S_IDLE) && !arm_i[c]) state_d[c] = S_IDLE;
      if (miss_clr_i[c]) miss_d[c] = '0;

      pulse_d[c] = (state_d[c] == S_PULSE);
    end
  end

  // Registers; trig_prev resets high so lines already asserted are not seen as edges
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trig_prev_q <= '1;
      pulse_q     <= '0;
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= S_IDLE;
        cnt_q[c]   <= '0;
        width_q[c] <= '0;
        hold_q[c]  <= '0;
        miss_q[c]  <= '0;
      end
    end else begin
      trig_prev_q <= dsp_trig_i;
      pulse_q     <= pulse_d;
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        width_q[c] <= width_d[c];
        hold_q[c]  <= hold_d[c];
        miss_q[c]  <= miss_d[c];
      end
    end
  end

endmodule

// File: tb/tb_exp_trig_pulse_sequencer.sv
// Bench for exp_trig_pulse_sequencer: directed scenarios plus random traffic, checked every
// cycle against a timestamp-based model of each channel's pulse window and busy interval.
module tb_exp_trig_pulse_sequencer;

  localparam int unsigned NCH = 8;
  localparam int unsigned CW  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       dsp;
  logic [NCH-1:0]    arm, sw, clr;
  logic [NCH*4-1:0]  sel;
  logic [NCH*CW-1:0] dly, wid, hld;
  logic [NCH-1:0]    pulse, busy;
  logic [NCH*8-1:0]  miss;

  always #5 clk = ~clk;

  exp_trig_pulse_sequencer #(.NCH(NCH), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst), .dsp_trig_i(dsp), .arm_i(arm), .sw_trig_i(sw),
    .src_sel_i(sel), .delay_i(dly), .width_i(wid), .holdoff_i(hld), .miss_clr_i(clr),
    .pulse_o(pulse), .busy_o(busy), .miss_cnt_o(miss)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  longint t        = 0;

  // Model: per channel, the cycle it is free again and the pulse window [pstart, pend]
  longint     free_at [NCH];
  longint     pstart  [NCH];
  longint     pend    [NCH];
  int         mmiss   [NCH];
  logic [15:0] mprev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        free_at[c] = 0; pstart[c] = 1; pend[c] = 0; mmiss[c] = 0;
      end
      mprev = '1;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        logic [3:0] s;
        logic       ev, is_busy;
        longint     d, w, h;
        s       = sel[4*c +: 4];
        ev      = arm[c] & ((dsp[s] & ~mprev[s]) | sw[c]);
        is_busy = (t < free_at[c]);
        d = longint'(dly[CW*c +: CW]);
        w = longint'(wid[CW*c +: CW]);
        h = longint'(hld[CW*c +: CW]);
        if (w == 0) w = 1;
        if (is_busy) begin
          if (ev && mmiss[c] < 255) mmiss[c]++;
          if (!arm[c]) begin
            free_at[c] = t + 1;
            if (pend[c] > t) pend[c] = t;
          end
        end else if (ev) begin
          pstart[c]  = t + 1 + d;
          pend[c]    = pstart[c] + w - 1;
          free_at[c] = pstart[c] + w + h;
        end
        if (clr[c]) mmiss[c] = 0;
      end
      mprev = dsp;
    end
  endtask

  // Advance one cycle with the current inputs, then compare all outputs with the model
  task automatic step();
    logic [NCH-1:0]   ep, eb;
    logic [NCH*8-1:0] em;
    model_update();
    @(posedge clk);
    #1;
    sw  = '0;
    clr = '0;
    t++;
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      ep[c]        = (t >= pstart[c]) && (t <= pend[c]);
      eb[c]        = (t < free_at[c]);
      em[8*c +: 8] = 8'(mmiss[c]);
    end
    check("pulse_vs_model", 64'(pulse), 64'(ep));
    check("busy_vs_model",  64'(busy),  64'(eb));
    check("miss_vs_model",  64'(miss),  64'(em));
  endtask

  task automatic cfg(input int c, input int s, input int d, input int w, input int h);
    sel[4*c +: 4]  = 4'(s);
    dly[CW*c +: CW] = CW'(d);
    wid[CW*c +: CW] = CW'(w);
    hld[CW*c +: CW] = CW'(h);
  endtask

  initial begin
    int seen;
    rst = 1'b1; dsp = '0; arm = '0; sw = '0; clr = '0;
    sel = '0; dly = '0; wid = '0; hld = '0;
    step(); step();
    check("reset_pulse", 64'(pulse), 64'd0);
    check("reset_busy",  64'(busy),  64'd0);
    check("reset_miss",  64'(miss),  64'd0);
    rst = 1'b0;

    // Basic timing: D=0 W=1 H=0 gives a single pulse the cycle after the edge
    cfg(0, 3, 0, 1, 0); arm = 8'h01;
    step(); step();
    dsp[3] = 1'b1; step();
    check("basic_pulse_t1", 64'(pulse[0]), 64'd1);
    step();
    check("basic_pulse_t2", 64'(pulse[0]), 64'd0);
    dsp[3] = 1'b0; step(); step();

    // Delayed pulse with holdoff; edge at T+19 is missed, strobe at T+20 accepted
    cfg(0, 3, 5, 4, 10);
    dsp[3] = 1'b1; step();
    for (int k = 1; k <= 21; k++) begin
      if (k == 5)  check("dly_pulse_t5",  64'(pulse[0]), 64'd0);
      if (k == 6)  check("dly_pulse_t6",  64'(pulse[0]), 64'd1);
      if (k == 9)  check("dly_pulse_t9",  64'(pulse[0]), 64'd1);
      if (k == 10) check("dly_pulse_t10", 64'(pulse[0]), 64'd0);
      if (k == 19) check("dly_busy_t19",  64'(busy[0]),  64'd1);
      if (k == 20) check("dly_busy_t20",  64'(busy[0]),  64'd0);
      if (k == 20) check("dly_miss_t20",  64'(miss[7:0]), 64'd1);
      if (k == 21) check("dly_busy_t21",  64'(busy[0]),  64'd1);
      dsp[3] = (k == 19);
      sw[0]  = (k == 20);
      step();
    end
    arm = '0; step(); arm = 8'h01;

    // Miss counter saturation and clear-wins-over-increment
    cfg(0, 3, 0, 1, 1000);
    clr[0] = 1'b1; step();
    sw[0] = 1'b1; step();
    for (int k = 0; k < 300; k++) begin sw[0] = 1'b1; step(); end
    check("miss_saturate", 64'(miss[7:0]), 64'd255);
    sw[0] = 1'b1; clr[0] = 1'b1; step();
    check("miss_clear_wins", 64'(miss[7:0]), 64'd0);
    arm = '0; step(); arm = 8'h01;

    // Disarm during PULSE
    cfg(0, 3, 2, 10, 0);
    sw[0] = 1'b1; step();
    step(); step(); step();
    check("disarm_in_pulse", 64'(pulse[0]), 64'd1);
    arm[0] = 1'b0; step();
    check("disarm_pulse_low", 64'(pulse[0]), 64'd0);
    check("disarm_busy_low",  64'(busy[0]),  64'd0);
    arm[0] = 1'b1;

    // Reset mid-DELAY: no pulse ever follows
    cfg(0, 3, 20, 3, 0);
    sw[0] = 1'b1; step();
    repeat (5) step();
    rst = 1'b1; step(); rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin step(); if (pulse[0]) seen++; end
    check("rst_mid_delay_no_pulse", 64'(seen), 64'd0);

    // Line held high through reset release is not an edge
    cfg(0, 0, 0, 1, 0);
    dsp[0] = 1'b1; rst = 1'b1; step(); rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin step(); if (pulse[0]) seen++; end
    check("held_high_no_pulse", 64'(seen), 64'd0);
    dsp[0] = 1'b0;

    // W=0 on all eight channels sharing one source
    for (int c = 0; c < NCH; c++) cfg(c, 5, 3, 0, 0);
    arm = '1; step();
    dsp[5] = 1'b1; step();
    step(); step(); step();
    check("shared_src_fire", 64'(pulse), 64'hff);
    step();
    check("shared_src_w0_end", 64'(pulse), 64'h00);
    dsp[5] = 1'b0; step();

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 4) begin
        int c;
        c = int'($urandom_range(0, NCH-1));
        if ($urandom_range(0, 9) == 0)
          cfg(c, int'($urandom_range(0, 15)), int'($urandom_range(0, 40)),
              int'($urandom_range(0, 20)), int'($urandom_range(0, 30)));
        else
          cfg(c, int'($urandom_range(0, 15)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 5)));
      end
      if ($urandom_range(0, 2) == 0) dsp = dsp ^ (16'd1 << $urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) arm[$urandom_range(0, NCH-1)] ^= 1'b1;
      for (int c = 0; c < NCH; c++) begin
        sw[c]  = ($urandom_range(0, 19) == 0);
        clr[c] = ($urandom_range(0, 99) == 0);
      end
      rst = ($urandom_range(0, 999) < 3);
      step();
    end
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
